syn_fifo_wr_arbiter: RTL and testbench
======================================

Name: syn_fifo_wr_arbiter

Overview:
- Shares the single write port of syn_fifo among NUM_REQ producers.
- Round-robin arbitration with locked bursts. A producer keeps ownership until it flags the last beat, reaches MAX_BURST beats, or drops its request.
- Uses the FIFO's full and half-full flags to stall writes and throttle bursts.
- Sits directly in front of syn_fifo's write side, in the write clock domain.

Parameters:
- NUM_REQ, 4, number of producers (2..8).
- DATA_WIDTH, 8, data width; must match syn_fifo.
- MAX_BURST, 4, maximum beats per ownership (1..15).

Ports:
- clk_i  in  1  write clock (sys_wclk domain).
- rstn_i  in  1  asynchronous active-low reset.
- req_i  in  NUM_REQ  per-producer write request; data is valid while req_i is high.
- last_i  in  NUM_REQ  per-producer last-beat flag, qualified by req_i.
- data_i  in  NUM_REQ x DATA_WIDTH  per-producer write data.
- gnt_o  out  NUM_REQ  one-hot accept; a beat transfers in any cycle where req_i[k] & gnt_o[k].
- fifo_full_i  in  1  syn_fifo full flag.
- fifo_half_full_i  in  1  syn_fifo half-full flag.
- fifo_we_o  out  1  syn_fifo write enable; equals |gnt_o.
- fifo_wdata_o  out  DATA_WIDTH  data of the granted producer; 0 when nothing is granted.
- owner_o  out  $clog2(NUM_REQ)  current or last owner index.
- busy_o  out  1  high in state BURST.
- stat_cnt_o  out  NUM_REQ x 16  per-producer accepted-beat counters (see Optional Feature).

Behaviour:
- Reset (rstn_i low, async):
  - State IDLE; rr_ptr=0, owner=0, beat_cnt=0.
  - gnt_o=0, fifo_we_o=0, fifo_wdata_o=0, owner_o=0, busy_o=0, stat_cnt_o=0.
- Reset mid-burst aborts ownership; the partial burst is not resumed.
- Grant path: gnt_o, fifo_we_o and fifo_wdata_o are combinational from registered state plus current inputs (zero latency). All state is registered on posedge clk_i.
- Full: gnt_o is all zero whenever fifo_full_i=1, in any state. fifo_we_o is never high while full. Ownership is kept.
- limit = 1 when fifo_half_full_i=1, else MAX_BURST. Sampled every cycle.
- State IDLE:
  - Winner = first k with req_i[k]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - If a winner exists and not full: gnt_o[winner]=1, owner<=winner, beat_cnt<=1.
  - If last_i[winner]=1 or limit==1: stay IDLE, rr_ptr<=winner+1 (mod NUM_REQ).
  - Otherwise go to BURST.
  - If no request or full: no change.
- State BURST:
  - gnt_o[owner] = req_i[owner] & ~full. Other producers are never granted.
  - On an accepted beat, beat_cnt increments.
  - Go to IDLE with rr_ptr<=owner+1 when the accepted beat has last_i=1, or the incremented beat_cnt >= limit.
  - If req_i[owner]=0: go to IDLE with rr_ptr<=owner+1, no grant that cycle (abort).
- Fairness: a producer requesting continuously is granted within (NUM_REQ-1) x MAX_BURST accepted beats.
- Wrap: rr_ptr wraps from NUM_REQ-1 to 0. beat_cnt never exceeds MAX_BURST.
- Simultaneous full and last: the beat is not accepted; ownership and state are held.

Optional Feature:
- Macro: SYN_FIFO_WARB_STATS_EN.
- Defined: each stat_cnt_o[k] increments on every accepted beat of producer k and saturates at 16'hFFFF. Reset to 0.
- Undefined: stat_cnt_o is tied to 0 and no counter flops are synthesized.
- Arbitration behaviour is identical either way.

Decomposition:
- Package syn_fifo_pkg holds:
  - typedef warb_state_e {IDLE, BURST}.
  - Constant WARB_STAT_W = 16.
  - Function rr_pick(req, ptr) returning the winner index and a valid bit.
- One sub-module: syn_fifo_rr_picker. Combinational rotate / priority-encode / unrotate used by the IDLE state. Parameterized by NUM_REQ.

Test Plan:
- All 4 producers request continuously with last_i=0, FIFO empty, no full:
  - Grants go 4 beats to producer 0, then 1, 2, 3, then 0 again.
  - fifo_we_o=1 every cycle; 16 beats fill syn_fifo.
- Producer 2 alone sends 3 beats with last_i high on beat 2:
  - Grants are beat 1 and beat 2 only; returns to IDLE; rr_ptr=3.
  - Beat 3 is re-arbitrated as a new ownership.
- Producer 1 is mid-burst and fifo_full_i rises for 3 cycles:
  - gnt_o=0 and fifo_we_o=0 for exactly 3 cycles; owner stays 1; the burst resumes after.
- fifo_half_full_i=1 with producers 0 and 3 requesting:
  - Single-beat alternation 0,3,0,3; busy_o stays 0.
- rstn_i pulsed low mid-burst:
  - All outputs 0 immediately (async), state IDLE.
  - The next grant goes to the lowest requesting index from rr_ptr=0.
- With SYN_FIFO_WARB_STATS_EN:
  - After the first scenario, stat_cnt_o = {4,4,4,4}.
  - After forcing 70000 beats on producer 0, stat_cnt_o[0]=16'hFFFF.

Source files
------------

// File: rtl/syn_fifo_pkg.sv
// Shared types and the round-robin pick helper for the syn_fifo write arbiter.
// rr_pick works on an 8-wide request vector; callers zero-extend narrower ones.
package syn_fifo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } warb_state_e;

    localparam int WARB_STAT_W = 16;
    localparam int RR_MAX_REQ  = 8;

    typedef struct packed {
        logic       vld;
        logic [2:0] idx;
    } rr_pick_t;

    // First set request at or after ptr, wrapping modulo n (n <= RR_MAX_REQ, ptr < n).
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] req,
                                         input logic [2:0]            ptr,
                                         input int                    n);
        rr_pick_t res;
        int       cand;
        res = '0;
        for (int i = 0; i < RR_MAX_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= n) cand = cand - n;
            if ((i < n) && !res.vld && req[cand[2:0]]) begin
                res.vld = 1'b1;
                res.idx = cand[2:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/syn_fifo_rr_picker.sv
// Round-robin picker: rotate by ptr, priority-encode, unrotate back to a producer index.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is granted.
module syn_fifo_rr_picker
    import syn_fifo_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               vld,
    output logic [IDX_W-1:0]   idx
);

    logic [RR_MAX_REQ-1:0] req_ext;
    rr_pick_t              pick;

    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req;
        pick                   = rr_pick(req_ext, 3'(ptr), NUM_REQ);
    end

    assign vld = pick.vld;
    assign idx = IDX_W'(pick.idx);

endmodule

// File: rtl/syn_fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing syn_fifo's write port; SYN_FIFO_WARB_STATS_EN adds beat counters.
// Latency: grant/write enable/data are combinational from registered state (zero cycles).
// Backpressure: fifo_full_i blocks every grant; fifo_half_full_i limits bursts to one beat.
module syn_fifo_wr_arbiter
    import syn_fifo_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                                     clk_i,
    input  logic                                     rstn_i,
    input  logic [NUM_REQ-1:0]                       req_i,
    input  logic [NUM_REQ-1:0]                       last_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]       data_i,
    output logic [NUM_REQ-1:0]                       gnt_o,
    input  logic                                     fifo_full_i,
    input  logic                                     fifo_half_full_i,
    output logic                                     fifo_we_o,
    output logic [DATA_WIDTH-1:0]                    fifo_wdata_o,
    output logic [$clog2(NUM_REQ)-1:0]               owner_o,
    output logic                                     busy_o,
    output logic [NUM_REQ-1:0][WARB_STAT_W-1:0]      stat_cnt_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    warb_state_e        state, state_d;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_d;
    logic [IDX_W-1:0]   owner, owner_d;
    logic [CNT_W-1:0]   beat_cnt, beat_d, beat_inc, lim;
    logic [NUM_REQ-1:0] gnt;
    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + IDX_W'(1);
    endfunction

    syn_fifo_rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
        .req (req_i),
        .ptr (rr_ptr),
        .vld (pick_vld),
        .idx (pick_idx)
    );

    assign lim      = fifo_half_full_i ? CNT_W'(1) : CNT_W'(MAX_BURST);
    assign beat_inc = beat_cnt + CNT_W'(1);

    always_comb begin
        gnt      = '0;
        state_d  = state;
        rr_ptr_d = rr_ptr;
        owner_d  = owner;
        beat_d   = beat_cnt;
        case (state)
            IDLE: begin
                if (pick_vld && !fifo_full_i) begin
                    gnt[pick_idx] = 1'b1;
                    owner_d       = pick_idx;
                    beat_d        = CNT_W'(1);
                    if (last_i[pick_idx] || (lim == CNT_W'(1))) begin
                        rr_ptr_d = next_idx(pick_idx);
                    end else begin
                        state_d = BURST;
                    end
                end
            end
            BURST: begin
                // A dropped request ends the burst even while the FIFO is full.
                if (!req_i[owner]) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_idx(owner);
                end else if (!fifo_full_i) begin
                    gnt[owner] = 1'b1;
                    beat_d     = beat_inc;
                    if (last_i[owner] || (beat_inc >= lim)) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_idx(owner);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_d;
            rr_ptr   <= rr_ptr_d;
            owner    <= owner_d;
            beat_cnt <= beat_d;
        end
    end

    // Grants are masked while reset is held so nothing is written during reset.
    assign gnt_o     = gnt & {NUM_REQ{rstn_i}};
    assign fifo_we_o = |gnt_o;
    assign owner_o   = owner;
    assign busy_o    = (state == BURST);

    always_comb begin
        fifo_wdata_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_o[k]) fifo_wdata_o = fifo_wdata_o | data_i[k];
        end
    end

`ifdef SYN_FIFO_WARB_STATS_EN
    logic [NUM_REQ-1:0][WARB_STAT_W-1:0] stat_cnt;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stat_cnt <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (gnt_o[k] && req_i[k] && (stat_cnt[k] != '1)) begin
                    stat_cnt[k] <= stat_cnt[k] + WARB_STAT_W'(1);
                end
            end
        end
    end

    assign stat_cnt_o = stat_cnt;
`else
    assign stat_cnt_o = '0;
`endif

endmodule

// File: tb/tb_syn_fifo_wr_arbiter.sv
// Scoreboard bench for syn_fifo_wr_arbiter: a reference model queues expected outputs per cycle,
// a monitor on the falling edge pops and compares them.
module tb_syn_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic [N-1:0]          req, last;
    logic [N-1:0][DW-1:0]  data;
    logic [N-1:0]          gnt_o;
    logic                  full, half;
    logic                  fifo_we_o;
    logic [DW-1:0]         fifo_wdata_o;
    logic [1:0]            owner_o;
    logic                  busy_o;
    logic [N-1:0][15:0]    stat_cnt_o;

    always #5 clk = ~clk;

    syn_fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk_i            (clk),
        .rstn_i           (rstn),
        .req_i            (req),
        .last_i           (last),
        .data_i           (data),
        .gnt_o            (gnt_o),
        .fifo_full_i      (full),
        .fifo_half_full_i (half),
        .fifo_we_o        (fifo_we_o),
        .fifo_wdata_o     (fifo_wdata_o),
        .owner_o          (owner_o),
        .busy_o           (busy_o),
        .stat_cnt_o       (stat_cnt_o)
    );

    typedef struct {
        logic [N-1:0]         gnt;
        logic                 we;
        logic [DW-1:0]        wdata;
        logic [1:0]           owner;
        logic                 busy;
        logic [N-1:0][15:0]   stat;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: who owns the port, how many beats so far, where the search starts.
    bit   m_burst;
    int   m_owner, m_ptr, m_cnt;
    int   m_stat[N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [N-1:0] rq, input logic [N-1:0] lst,
                         input logic fl, input logic hf, input logic rst);
        exp_t e;
        int   g, win, lim, k;
        @(posedge clk);
        #1;
        rstn = !rst;
        req  = rq;
        last = lst;
        full = fl;
        half = hf;
        for (int i = 0; i < N; i++) data[i] = DW'($urandom);
        g = -1;
        if (rst) begin
            m_burst = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
            for (int i = 0; i < N; i++) m_stat[i] = 0;
        end
        e.owner = 2'(m_owner);
        e.busy  = m_burst;
        for (int i = 0; i < N; i++) begin
`ifdef SYN_FIFO_WARB_STATS_EN
            e.stat[i] = 16'(m_stat[i]);
`else
            e.stat[i] = 16'd0;
`endif
        end
        if (!rst) begin
            lim = hf ? 1 : MB;
            if (!m_burst) begin
                win = -1;
                for (int i = 0; i < N; i++) begin
                    k = (m_ptr + i) % N;
                    if (win < 0 && rq[k]) win = k;
                end
                if (win >= 0 && !fl) begin
                    g = win; m_owner = win; m_cnt = 1;
                    if (lst[win] || lim == 1) m_ptr = (win + 1) % N;
                    else m_burst = 1;
                end
            end else begin
                if (!rq[m_owner]) begin
                    m_burst = 0; m_ptr = (m_owner + 1) % N;
                end else if (!fl) begin
                    g = m_owner; m_cnt++;
                    if (lst[m_owner] || m_cnt >= lim) begin
                        m_burst = 0; m_ptr = (m_owner + 1) % N;
                    end
                end
            end
        end
        e.gnt   = '0;
        e.we    = (g >= 0);
        e.wdata = '0;
        if (g >= 0) begin
            e.gnt[g] = 1'b1;
            e.wdata  = data[g];
            if (m_stat[g] < 65535) m_stat[g]++;
        end
        sb_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("gnt",   64'(gnt_o),        64'(e.gnt));
                chk("we",    64'(fifo_we_o),    64'(e.we));
                chk("wdata", 64'(fifo_wdata_o), 64'(e.wdata));
                chk("owner", 64'(owner_o),      64'(e.owner));
                chk("busy",  64'(busy_o),       64'(e.busy));
                chk("stat",  64'(stat_cnt_o),   64'(e.stat));
            end
        end
    end

    initial begin : stim
        logic [N-1:0] rq, lst;
        logic [3:0]   exp_g;
        logic [63:0]  exp_stat;
        rstn = 1'b0; req = '0; last = '0; full = 1'b0; half = 1'b0; data = '0;
        m_burst = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
        for (int i = 0; i < N; i++) m_stat[i] = 0;

        // Reset state, then all four producers stream: 4 beats each in order 0,1,2,3.
        drive('0, '0, 1'b0, 1'b0, 1'b1);
        drive('0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            drive(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            exp_g = 4'b0001 << (i / 4);
            chk("s1_gnt", 64'(gnt_o), 64'(exp_g));
        end
        drive('0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
`ifdef SYN_FIFO_WARB_STATS_EN
        exp_stat = {16'd4, 16'd4, 16'd4, 16'd4};
        chk("s1_stat", 64'(stat_cnt_o), exp_stat);
`endif

        // Producer 2 alone, last on beat 2; beat 3 becomes a fresh ownership from IDLE.
        drive('0, '0, 1'b0, 1'b0, 1'b1);
        drive(4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0);
        drive(4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0);
        drive(4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("s2_busy_beat3", 64'(busy_o), 64'd0);
        chk("s2_gnt_beat3",  64'(gnt_o),  64'(4'b0100));
        drive('0, '0, 1'b0, 1'b0, 1'b0);

        // Producer 1 mid-burst sees three full cycles, then finishes its burst.
        drive('0, '0, 1'b0, 1'b0, 1'b1);
        drive(4'b0010, '0, 1'b0, 1'b0, 1'b0);
        drive(4'b0010, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(4'b0010, '0, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            chk("s3_full_we",    64'(fifo_we_o), 64'd0);
            chk("s3_full_owner", 64'(owner_o),   64'd1);
        end
        drive(4'b0010, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("s3_resume", 64'(gnt_o), 64'(4'b0010));
        drive(4'b0010, '0, 1'b0, 1'b0, 1'b0);
        drive('0, '0, 1'b0, 1'b0, 1'b0);

        // Half-full: single-beat alternation between producers 0 and 3.
        drive('0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(4'b1001, '0, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            exp_g = (i % 2 == 0) ? 4'b0001 : 4'b1000;
            chk("s4_gnt",  64'(gnt_o),  64'(exp_g));
            chk("s4_busy", 64'(busy_o), 64'd0);
        end

        // Move rr_ptr to 3, start a burst, reset mid-burst, check rr_ptr restarts at 0.
        drive('0, '0, 1'b0, 1'b0, 1'b1);
        drive(4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0);
        drive(4'b1111, '0, 1'b0, 1'b0, 1'b0);
        drive(4'b1111, '0, 1'b0, 1'b0, 1'b0);
        drive(4'b1111, '0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("s5_rst_gnt",  64'(gnt_o),  64'd0);
        chk("s5_rst_busy", 64'(busy_o), 64'd0);
        drive(4'b1010, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("s5_after_rst", 64'(gnt_o), 64'(4'b0010));

        // Randomized traffic with occasional full, half-full and reset.
        for (int i = 0; i < 3000; i++) begin
            rq  = N'($urandom);
            lst = (($urandom % 4) == 0) ? N'($urandom) : '0;
            drive(rq, lst, (($urandom % 8) == 0), (($urandom % 6) == 0), (($urandom % 300) == 0));
        end

`ifdef SYN_FIFO_WARB_STATS_EN
        drive('0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 70000; i++) drive(4'b0001, '0, 1'b0, 1'b0, 1'b0);
        drive('0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("stat0_sat", 64'(stat_cnt_o[0]), 64'hFFFF);
`endif

        drive('0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        if (sb_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d expected=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
